// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC fetch stage.
package npc_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [6:0]  OPC_BAD      = 7'b1111111;
    localparam logic [31:0] FAULT_INST   = {25'd0, OPC_BAD};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } fetch_ent_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small FIFO of {pc, inst, fault} entries between fetch and decode.
// Flush empties it in one cycle and wins over any push or pop.
module ifu_fifo
    import npc_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [31:0]              i_pc,
    input  logic [31:0]              i_inst,
    input  logic                     i_fault,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [31:0]              o_pc,
    output logic [31:0]              o_inst,
    output logic                     o_fault,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_ent_t        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop && (r_count != {CW{1'b0}});
    assign w_push = i_push && ((r_count != FULL) || w_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{pc: i_pc, inst: i_inst, fault: i_fault};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = r_count != {CW{1'b0}};
    assign o_pc    = r_mem[r_rd_ptr].pc;
    assign o_inst  = r_mem[r_rd_ptr].inst;
    assign o_fault = r_mem[r_rd_ptr].fault;
    assign o_count = r_count;

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, keeps one instruction-memory read in flight and
// queues returned instructions for decode. Redirects flush; halt is sticky.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] FULL    = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] FULL_M1 = CW'(BUF_DEPTH - 1);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   r_fetch_pc;
    logic          r_kill;
    logic          r_pend;
    logic          r_req_valid;
    logic          w_hs;
    logic          w_rsp_take;
    logic          w_pend_nxt;
    logic          w_room_now;
    logic          w_room_after;
    logic          w_push;
    logic [31:0]   w_push_pc;
    logic [31:0]   w_push_inst;
    logic          w_push_fault;
    logic [CW-1:0] w_count;

    assign w_hs         = r_req_valid && imem_req_ready;
    assign w_rsp_take   = r_pend && imem_rsp_valid;
    assign w_pend_nxt   = w_hs || (r_pend && !imem_rsp_valid);
    assign w_room_now   = w_count < FULL;
    assign w_room_after = w_push ? (w_count < FULL_M1) : w_room_now;

    // FIFO push source: a returned response, or a misaligned-PC fault raised at issue time
    always_comb begin
        w_push       = 1'b0;
        w_push_pc    = r_fetch_pc;
        w_push_inst  = FAULT_INST;
        w_push_fault = 1'b0;
        if (redirect_valid) begin
            w_push = 1'b0;
        end else if (w_rsp_take && !r_kill) begin
            w_push       = 1'b1;
            w_push_pc    = r_fetch_pc;
            w_push_inst  = imem_rsp_err ? FAULT_INST : imem_rsp_data;
            w_push_fault = imem_rsp_err;
        end else if ((r_state == ST_IDLE) && !halt && w_room_now && misaligned(r_pc)) begin
            w_push       = 1'b1;
            w_push_pc    = r_pc;
            w_push_inst  = FAULT_INST;
            w_push_fault = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // Next fetch state; WAIT goes straight back to REQ when room remains, giving 2-cycle throughput
    always_comb begin
        w_state_nxt = r_state;
        if (halt) begin
            w_state_nxt = ST_HALT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!redirect_valid && w_room_now) begin
                        w_state_nxt = misaligned(r_pc) ? ST_HALT : ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (w_hs) begin
                        w_state_nxt = ST_WAIT;
                    end else if (redirect_valid && misaligned(redirect_pc)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (!redirect_valid && w_room_after && !misaligned(r_pc)) begin
                            w_state_nxt = ST_REQ;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_HALT: w_state_nxt = ST_HALT;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state, PC, kill/pending tracking and registered request outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= RESET_PC;
            r_kill      <= 1'b0;
            r_pend      <= 1'b0;
            r_req_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_valid <= (w_state_nxt == ST_REQ);
            r_pend      <= w_pend_nxt;
            if (redirect_valid) begin
                r_kill <= w_pend_nxt;
            end else if (w_rsp_take) begin
                r_kill <= 1'b0;
            end
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_hs) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_hs) begin
                r_fetch_pc <= r_pc;
            end
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;

    ifu_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pc    (w_push_pc),
        .i_inst  (w_push_inst),
        .i_fault (w_push_fault),
        .i_pop   (out_ready),
        .o_valid (out_valid),
        .o_pc    (out_pc),
        .o_inst  (out_inst),
        .o_fault (out_fault),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: an in-order stream model with a memory responder,
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_ifu_fetch;

    localparam logic [31:0] RPC   = 32'h8000_0000;
    localparam logic [31:0] MAGIC = 32'h1357_9BDF;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        f;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        imem_rsp_err = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_pc, out_inst;

    int checks = 0;
    int errors = 0;

    ent_t        exp_q[$];
    ent_t        out_log[$];
    logic [31:0] hs_log[$];
    logic [31:0] m_pc;
    logic        m_stopped;
    logic        rec_active, rec_killed;
    logic [31:0] rec_addr;
    int          rec_wait;
    int          mem_lat;
    logic [31:0] err_addr;
    logic        nxt_v, nxt_e;
    logic [31:0] nxt_d;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream model: evaluated mid-cycle, applies this cycle's handshakes
    task automatic mon();
        ent_t e;
        if (!rst) begin
            exp_q.delete();
            m_pc       = RPC;
            m_stopped  = 1'b0;
            rec_active = 1'b0;
            rec_killed = 1'b0;
            nxt_v      = 1'b0;
            return;
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_valid_empty_model", 32'(out_valid), 32'd0);
            end else begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_inst", out_inst, exp_q[0].inst);
                chk("out_fault", 32'(out_fault), 32'(exp_q[0].f));
            end
        end
        if (out_valid && out_ready && !redirect_valid && exp_q.size() != 0) begin
            e.pc = out_pc; e.inst = out_inst; e.f = out_fault;
            out_log.push_back(e);
            e = exp_q.pop_front();
        end
        if (imem_rsp_valid) begin
            if (rec_active && !rec_killed && !redirect_valid) begin
                e.pc   = rec_addr;
                e.f    = (rec_addr == err_addr);
                e.inst = e.f ? 32'h0000_007F : (rec_addr ^ MAGIC);
                exp_q.push_back(e);
            end
            rec_active = 1'b0;
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, m_pc);
            chk("req_while_stopped", 32'(m_stopped), 32'd0);
            hs_log.push_back(imem_req_addr);
            rec_active = 1'b1;
            rec_killed = 1'b0;
            rec_addr   = m_pc;
            rec_wait   = mem_lat;
            m_pc       = m_pc + 32'd4;
        end
        if (redirect_valid) begin
            exp_q.delete();
            if (rec_active) rec_killed = 1'b1;
            m_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                e.pc = redirect_pc; e.inst = 32'h0000_007F; e.f = 1'b1;
                exp_q.push_back(e);
                m_stopped = 1'b1;
            end
        end
        if (halt) m_stopped = 1'b1;
        chk("model_occupancy_le2", 32'(exp_q.size() <= 2), 32'd1);
        nxt_v = 1'b0;
        if (rec_active) begin
            if (rec_wait == 0) begin
                nxt_v = 1'b1;
                nxt_d = rec_addr ^ MAGIC;
                nxt_e = (rec_addr == err_addr);
            end else begin
                rec_wait--;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        imem_rsp_valid = nxt_v;
        imem_rsp_data  = nxt_v ? nxt_d : 32'd0;
        imem_rsp_err   = nxt_v ? nxt_e : 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        while (hs_log.size() < n && t < 300) begin tick(); t++; end
        chk("hs_timeout", 32'(hs_log.size() >= n), 32'd1);
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (out_log.size() < n && t < 300) begin tick(); t++; end
        chk("out_timeout", 32'(out_log.size() >= n), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, RPC);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_pc"}, out_pc, 32'd0);
        chk({tag, "_out_inst"}, out_inst, 32'd0);
        chk({tag, "_out_fault"}, 32'(out_fault), 32'd0);
    endtask

    task automatic restart();
        rst = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) tick();
        hs_log.delete();
        out_log.delete();
        rst = 1'b1;
    endtask

    initial begin
        int h, o;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        halt           = 1'b0;
        mem_lat        = 0;
        err_addr       = 32'hFFFF_FFFF;
        nxt_v = 1'b0; nxt_d = 32'd0; nxt_e = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b1;

        // 1: sequential fetch with zero-wait memory
        wait_hs(3);
        chk("t1_addr0", hs_log[0], 32'h8000_0000);
        chk("t1_addr1", hs_log[1], 32'h8000_0004);
        chk("t1_addr2", hs_log[2], 32'h8000_0008);
        wait_out(3);
        chk("t1_out0", out_log[0].pc, 32'h8000_0000);
        chk("t1_out1", out_log[1].pc, 32'h8000_0004);
        chk("t1_out2", out_log[2].pc, 32'h8000_0008);
        chk("t1_inst0", out_log[0].inst, 32'h9357_9BDF);

        // 2: back-pressure fills exactly two entries, then drains without loss
        out_ready = 1'b0;
        repeat (20) tick();
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_req_idle", 32'(imem_req_valid), 32'd0);
        h = hs_log.size();
        repeat (5) tick();
        chk("t2_no_new_req", 32'(hs_log.size()), 32'(h));
        chk("t2_model_two", 32'(exp_q.size()), 32'd2);
        o = out_log.size();
        out_ready = 1'b1;
        tick();
        tick();
        chk("t2_two_pops", 32'(out_log.size() - o), 32'd2);
        wait_out(o + 4);
        for (int k = 1; k < out_log.size(); k++) begin
            chk("t2_seq_pc", out_log[k].pc, out_log[k-1].pc + 32'd4);
        end

        // 3: redirect while waiting on a slow response
        mem_lat = 3;
        h = hs_log.size();
        wait_hs(h + 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        o = out_log.size();
        tick();
        redirect_valid = 1'b0;
        wait_out(o + 2);
        chk("t3_first", out_log[o].pc, 32'h8000_0100);
        chk("t3_second", out_log[o+1].pc, 32'h8000_0104);
        mem_lat = 0;

        // 4: access fault on the third fetch
        restart();
        err_addr = 32'h8000_0008;
        wait_out(3);
        chk("t4_pc", out_log[2].pc, 32'h8000_0008);
        chk("t4_inst", out_log[2].inst, 32'h0000_007F);
        chk("t4_fault", 32'(out_log[2].f), 32'd1);
        chk("t4_prev_inst", out_log[1].inst, 32'h9357_9BDB);
        chk("t4_prev_fault", 32'(out_log[1].f), 32'd0);

        // 5: misaligned redirect produces a single fault entry and stops fetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        o = out_log.size();
        tick();
        redirect_valid = 1'b0;
        wait_out(o + 1);
        chk("t5_pc", out_log[o].pc, 32'h8000_0102);
        chk("t5_inst", out_log[o].inst, 32'h0000_007F);
        chk("t5_fault", 32'(out_log[o].f), 32'd1);
        h = hs_log.size();
        repeat (15) tick();
        chk("t5_no_req", 32'(hs_log.size()), 32'(h));
        chk("t5_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t5_empty", 32'(out_valid), 32'd0);
        err_addr = 32'hFFFF_FFFF;

        // 6: halt during an outstanding read, then async reset mid-stream
        restart();
        mem_lat = 3;
        wait_hs(2);
        halt = 1'b1;
        wait_out(2);
        chk("t6_pending_pc", out_log[1].pc, 32'h8000_0004);
        repeat (10) tick();
        chk("t6_req_count", 32'(hs_log.size()), 32'd2);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);

        restart();
        mem_lat   = 0;
        out_ready = 1'b0;
        repeat (10) tick();
        chk("t6_buffered", 32'(out_valid), 32'd1);
        chk("t6_head_pc", out_pc, 32'h8000_0000);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("async_rst");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
